// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry controller: state and key-event
// encodings, the digit range limit, default parameters and the key arbiter.
package calc_pkg;

  localparam int NUM_OPERANDS_DEF = 2;
  localparam int MAX_DIGITS_DEF   = 4;
  localparam int OPC_W_DEF        = 2;

  // Largest key_digit value that counts as a decimal digit.
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  typedef enum logic [2:0] {
    ST_SIGN   = 3'd0,
    ST_DIGITS = 3'd1,
    ST_EXEC   = 3'd2,
    ST_RESULT = 3'd3
  } state_t;

  // The single key event accepted in a cycle after priority arbitration.
  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_RECALL   = 3'd1,
    EV_EQUALS   = 3'd2,
    EV_OPERATOR = 3'd3,
    EV_NEGATIVE = 3'd4,
    EV_DIGIT    = 3'd5
  } event_t;

  // Fixed priority: recall > equals > operator > negative > digit.
  // Lower-priority strobes in the same cycle are simply dropped.
  function automatic event_t pick_event(
    input logic recall,
    input logic equals,
    input logic oper,
    input logic negative,
    input logic digit_ok
  );
    event_t ev;
    if (recall) begin
      ev = EV_RECALL;
    end else if (equals) begin
      ev = EV_EQUALS;
    end else if (oper) begin
      ev = EV_OPERATOR;
    end else if (negative) begin
      ev = EV_NEGATIVE;
    end else if (digit_ok) begin
      ev = EV_DIGIT;
    end else begin
      ev = EV_NONE;
    end
    return ev;
  endfunction

endpackage

// File: rtl/calc_digit_counter.sv
// Digit counter for the active operand slot. Saturates at MAX_DIGITS and
// reports full so the controller can reject further digits.
module calc_digit_counter
  import calc_pkg::*;
#(
  parameter int MAX_DIGITS = MAX_DIGITS_DEF,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load_one,
  input  logic             load_max,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_DIGITS);

  // Count register: clear/load take precedence over increment; increment saturates.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt <= {CNT_W{1'b0}};
    end else if (load_max) begin
      cnt <= CNT_MAX;
    end else if (load_one) begin
      cnt <= CNT_W'(1);
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_W'(1);
    end else begin
      cnt <= cnt;
    end
  end

  assign full = (cnt == CNT_MAX);

endmodule

// File: rtl/calc_entry_ctrl.sv
// Key-entry controller for a small calculator: captures sign and digits for
// NUM_OPERANDS operand slots, launches the ALU, and supports chained results.
module calc_entry_ctrl
  import calc_pkg::*;
#(
  parameter int NUM_OPERANDS = NUM_OPERANDS_DEF,
  parameter int MAX_DIGITS   = MAX_DIGITS_DEF,
  parameter int OPC_W        = OPC_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              key_valid,
  input  logic [3:0]                        key_digit,
  input  logic                              key_negative,
  input  logic                              key_operator,
  input  logic [OPC_W-1:0]                  key_opcode,
  input  logic                              key_equals,
  input  logic                              key_recall,
  input  logic                              alu_done,
  output logic [2:0]                        state,
  output logic [NUM_OPERANDS-1:0]           slot_sel,
  output logic                              digit_we,
  output logic [3:0]                        digit_data,
  output logic [$clog2(MAX_DIGITS+1)-1:0]   digit_cnt,
  output logic                              recall_we,
  output logic [NUM_OPERANDS-1:0]           operand_neg,
  output logic [OPC_W-1:0]                  opcode_q,
  output logic                              alu_start,
  output logic                              busy,
  output logic                              overflow_err
);

  localparam int K_W   = (NUM_OPERANDS > 1) ? $clog2(NUM_OPERANDS) : 1;
  localparam int CNT_W = $clog2(MAX_DIGITS + 1);
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_OPERANDS - 1);
  localparam logic [NUM_OPERANDS-1:0] SLOT0 = NUM_OPERANDS'(1);
  localparam logic [NUM_OPERANDS-1:0] NO_SLOT = {NUM_OPERANDS{1'b0}};

  state_t            state_r, state_nxt;
  logic [K_W-1:0]    k_r, k_nxt;
  event_t            ev;
  logic              digit_ok;

  logic              cnt_clr, cnt_one, cnt_max, cnt_inc, cnt_full;

  logic                    digit_we_nxt, recall_we_nxt, alu_start_nxt;
  logic [NUM_OPERANDS-1:0] neg_nxt, slot_sel_nxt;
  logic [OPC_W-1:0]        opc_nxt;
  logic                    ovf_nxt;

  assign digit_ok = key_valid && (key_digit <= DIGIT_MAX);
  assign ev       = pick_event(key_recall, key_equals, key_operator, key_negative, digit_ok);
  assign state    = state_r;

  calc_digit_counter #(
    .MAX_DIGITS (MAX_DIGITS),
    .CNT_W      (CNT_W)
  ) u_digit_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load_one (cnt_one),
    .load_max (cnt_max),
    .inc      (cnt_inc),
    .cnt      (digit_cnt),
    .full     (cnt_full)
  );

  // State and slot-index register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_SIGN;
      k_r     <= {K_W{1'b0}};
    end else begin
      state_r <= state_nxt;
      k_r     <= k_nxt;
    end
  end

  // Next-state and next slot index from the arbitrated key event.
  always_comb begin
    state_nxt = state_r;
    k_nxt     = k_r;
    case (state_r)
      ST_SIGN: begin
        if ((ev == EV_RECALL) || (ev == EV_DIGIT)) begin
          state_nxt = ST_DIGITS;
        end else begin
          state_nxt = ST_SIGN;
        end
      end
      ST_DIGITS: begin
        if ((ev == EV_EQUALS) && (k_r == K_LAST)) begin
          state_nxt = ST_EXEC;
        end else if ((ev == EV_OPERATOR) && (k_r != K_LAST)) begin
          state_nxt = ST_SIGN;
          k_nxt     = k_r + K_W'(1);
        end else begin
          state_nxt = ST_DIGITS;
        end
      end
      ST_EXEC: begin
        if (alu_done) begin
          state_nxt = ST_RESULT;
        end else begin
          state_nxt = ST_EXEC;
        end
      end
      ST_RESULT: begin
        if (ev == EV_DIGIT) begin
          state_nxt = ST_DIGITS;
          k_nxt     = {K_W{1'b0}};
        end else if (ev == EV_NEGATIVE) begin
          state_nxt = ST_SIGN;
          k_nxt     = {K_W{1'b0}};
        end else if (ev == EV_OPERATOR) begin
          // The result occupies slot 0; entry continues in slot 1.
          state_nxt = ST_SIGN;
          k_nxt     = K_W'(1);
        end else begin
          state_nxt = ST_RESULT;
        end
      end
      default: begin
        state_nxt = ST_SIGN;
        k_nxt     = {K_W{1'b0}};
      end
    endcase
  end

  // Next values of the registered outputs and digit-counter controls.
  always_comb begin
    digit_we_nxt  = 1'b0;
    recall_we_nxt = 1'b0;
    alu_start_nxt = 1'b0;
    neg_nxt       = operand_neg;
    opc_nxt       = opcode_q;
    ovf_nxt       = overflow_err;
    cnt_clr       = 1'b0;
    cnt_one       = 1'b0;
    cnt_max       = 1'b0;
    cnt_inc       = 1'b0;
    case (state_r)
      ST_SIGN: begin
        case (ev)
          EV_RECALL: begin
            recall_we_nxt = 1'b1;
            cnt_max       = 1'b1;
          end
          EV_NEGATIVE: neg_nxt[k_r] = ~operand_neg[k_r];
          EV_DIGIT: begin
            digit_we_nxt = 1'b1;
            cnt_one      = 1'b1;
          end
          default: digit_we_nxt = 1'b0;
        endcase
      end
      ST_DIGITS: begin
        case (ev)
          EV_RECALL: begin
            recall_we_nxt = 1'b1;
            cnt_max       = 1'b1;
          end
          EV_EQUALS: begin
            if (k_r == K_LAST) begin
              alu_start_nxt = 1'b1;
            end else begin
              alu_start_nxt = 1'b0;
            end
          end
          EV_OPERATOR: begin
            if (k_r != K_LAST) begin
              opc_nxt = key_opcode;
              cnt_clr = 1'b1;
            end else begin
              opc_nxt = opcode_q;
            end
          end
          EV_DIGIT: begin
            if (cnt_full) begin
              ovf_nxt = 1'b1;
            end else begin
              digit_we_nxt = 1'b1;
              cnt_inc      = 1'b1;
            end
          end
          default: digit_we_nxt = 1'b0;
        endcase
      end
      ST_RESULT: begin
        case (ev)
          EV_DIGIT: begin
            neg_nxt      = NO_SLOT;
            ovf_nxt      = 1'b0;
            digit_we_nxt = 1'b1;
            cnt_one      = 1'b1;
          end
          EV_NEGATIVE: begin
            neg_nxt = SLOT0;
            ovf_nxt = 1'b0;
            cnt_clr = 1'b1;
          end
          EV_OPERATOR: begin
            // Sign flags restart: the result's sign is owned by the datapath.
            neg_nxt = NO_SLOT;
            opc_nxt = key_opcode;
            cnt_clr = 1'b1;
          end
          default: digit_we_nxt = 1'b0;
        endcase
      end
      default: digit_we_nxt = 1'b0;
    endcase

    if ((state_nxt == ST_SIGN) || (state_nxt == ST_DIGITS)) begin
      slot_sel_nxt = SLOT0 << k_nxt;
    end else begin
      slot_sel_nxt = NO_SLOT;
    end
  end

  // Output register stage: every response appears the cycle after the key.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_sel     <= SLOT0;
      digit_we     <= 1'b0;
      digit_data   <= 4'd0;
      recall_we    <= 1'b0;
      operand_neg  <= NO_SLOT;
      opcode_q     <= {OPC_W{1'b0}};
      alu_start    <= 1'b0;
      busy         <= 1'b0;
      overflow_err <= 1'b0;
    end else begin
      slot_sel     <= slot_sel_nxt;
      digit_we     <= digit_we_nxt;
      digit_data   <= digit_we_nxt ? key_digit : digit_data;
      recall_we    <= recall_we_nxt;
      operand_neg  <= neg_nxt;
      opcode_q     <= opc_nxt;
      alu_start    <= alu_start_nxt;
      busy         <= (state_nxt == ST_EXEC);
      overflow_err <= ovf_nxt;
    end
  end

endmodule
